// File: rtl/fp_mul_pipe.sv
// fp_mul_pipe: three-stage IEEE-754-style floating-point multiplier.
// Stage 1 unpacks the operands, detects special cases and sums the exponents.
// Stage 2 forms the full significand product.
// Stage 3 normalises, rounds to nearest-even and packs the result and flags.
// Subnormal inputs are flushed to signed zero.
// Results that would be subnormal are flushed to signed zero and raise underflow.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// A producer holds valid and its data stable until that edge.
// ready never depends on valid from the same side.
// Every stage register loads when it is empty or when its successor is loading.
// As a result, in_ready = !s1 valid || stage 2 can take stage 1's contents.
// out_valid comes straight from a register.
// No combinational path therefore exists from in_valid to out_valid.
module fp_mul_pipe #(
   parameter int EXP_W = 5,
   parameter int MAN_W = 10
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   a,
   input  logic [EXP_W+MAN_W:0]   b,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);

   localparam int W       = 1 + EXP_W + MAN_W;
   localparam int PW      = 2 * MAN_W + 2;
   localparam int EW      = EXP_W + 2;
   localparam int BIAS    = (1 << (EXP_W - 1)) - 1;
   localparam int EXP_MAX = (1 << EXP_W) - 1;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   // ---------------- handshake / stage enables ----------------
   logic v1, v2, v3;
   logic rdy1, rdy2, rdy3;

   assign rdy3      = !v3 || out_ready;
   assign rdy2      = !v2 || rdy3;
   assign rdy1      = !v1 || rdy2;
   assign in_ready  = rdy1;
   assign out_valid = v3;

   // ---------------- stage 1: unpack and classify ----------------
   logic               sa, sb, s_xor;
   logic [EXP_W-1:0]   ea, eb;
   logic [MAN_W-1:0]   fa, fb;
   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_snan, b_snan;
   logic               spec_d;
   logic [W-1:0]       spec_res_d;
   logic [3:0]         spec_flags_d;
   logic signed [EW-1:0] exp_sum_d;

   assign {sa, ea, fa} = a;
   assign {sb, eb, fb} = b;
   assign s_xor  = sa ^ sb;
   assign a_zero = (ea == '0);
   assign b_zero = (eb == '0);
   assign a_inf  = (&ea) && (fa == '0);
   assign b_inf  = (&eb) && (fb == '0);
   assign a_nan  = (&ea) && (fa != '0);
   assign b_nan  = (&eb) && (fb != '0);
   assign a_snan = a_nan && !fa[MAN_W-1];
   assign b_snan = b_nan && !fb[MAN_W-1];
   assign exp_sum_d = $signed(EW'(ea)) + $signed(EW'(eb)) - $signed(EW'(BIAS));

   // Special-case result. NaN has the highest priority, then inf x 0, inf, and zero.
   always_comb begin
      spec_d       = 1'b1;
      spec_res_d   = '0;
      spec_flags_d = 4'b0000;
      if (a_nan || b_nan) begin
         spec_res_d   = QNAN;
         spec_flags_d = {a_snan || b_snan, 3'b000};
      end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
         spec_res_d   = QNAN;
         spec_flags_d = 4'b1000;
      end else if (a_inf || b_inf) begin
         spec_res_d   = {s_xor, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
         spec_res_d   = {s_xor, {(W-1){1'b0}}};
      end else begin
         spec_d       = 1'b0;
      end
   end

   logic                 s1_sign, s1_spec;
   logic signed [EW-1:0] s1_exp;
   logic [MAN_W:0]       s1_siga, s1_sigb;
   logic [W-1:0]         s1_spec_res;
   logic [3:0]           s1_spec_flags;

   // Stage 1 register: capture the operands unpacked, with the hidden 1 restored.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1            <= 1'b0;
         s1_sign       <= 1'b0;
         s1_spec       <= 1'b0;
         s1_exp        <= '0;
         s1_siga       <= '0;
         s1_sigb       <= '0;
         s1_spec_res   <= '0;
         s1_spec_flags <= '0;
      end else if (rdy1) begin
         v1            <= in_valid;
         s1_sign       <= s_xor;
         s1_spec       <= spec_d;
         s1_exp        <= exp_sum_d;
         s1_siga       <= {1'b1, fa};
         s1_sigb       <= {1'b1, fb};
         s1_spec_res   <= spec_res_d;
         s1_spec_flags <= spec_flags_d;
      end
   end

   // ---------------- stage 2: significand product ----------------
   logic [PW-1:0]        prod_d;
   logic                 s2_sign, s2_spec;
   logic signed [EW-1:0] s2_exp;
   logic [PW-1:0]        s2_prod;
   logic [W-1:0]         s2_spec_res;
   logic [3:0]           s2_spec_flags;

   assign prod_d = PW'(s1_siga) * PW'(s1_sigb);

   // Stage 2 register: hold the full-width product alongside the stage 1 side data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2            <= 1'b0;
         s2_sign       <= 1'b0;
         s2_spec       <= 1'b0;
         s2_exp        <= '0;
         s2_prod       <= '0;
         s2_spec_res   <= '0;
         s2_spec_flags <= '0;
      end else if (rdy2) begin
         v2            <= v1;
         s2_sign       <= s1_sign;
         s2_spec       <= s1_spec;
         s2_exp        <= s1_exp;
         s2_prod       <= prod_d;
         s2_spec_res   <= s1_spec_res;
         s2_spec_flags <= s1_spec_flags;
      end
   end

   // ---------------- stage 3: normalise, round, pack ----------------
   logic [PW-2:0]        pn;
   logic [MAN_W-1:0]     man;
   logic                 guard, sticky, round_up;
   logic [MAN_W:0]       man_r;
   logic signed [EW-1:0] exp_n;
   logic [W-1:0]         res_d;
   logic [3:0]           flags_d;

   // Normalise the product to 1.x, then round to nearest-even.
   // A rounding carry moves the result up to the next binade.
   always_comb begin
      pn       = s2_prod[PW-1] ? s2_prod[PW-2:0] : {s2_prod[PW-3:0], 1'b0};
      man      = pn[2*MAN_W:MAN_W+1];
      guard    = pn[MAN_W];
      sticky   = |pn[MAN_W-1:0];
      round_up = guard && (sticky || man[0]);
      man_r    = {1'b0, man} + {{MAN_W{1'b0}}, round_up};
      exp_n    = s2_exp + $signed({{(EW-1){1'b0}}, s2_prod[PW-1]})
                        + $signed({{(EW-1){1'b0}}, man_r[MAN_W]});
      res_d    = {s2_sign, exp_n[EXP_W-1:0], man_r[MAN_W-1:0]};
      flags_d  = {3'b000, guard || sticky};
      if (s2_spec) begin
         res_d   = s2_spec_res;
         flags_d = s2_spec_flags;
      end else if (exp_n >= $signed(EW'(EXP_MAX))) begin
         res_d   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         flags_d = 4'b0101;
      end else if (exp_n <= 0) begin
         res_d   = {s2_sign, {(W-1){1'b0}}};
         flags_d = 4'b0011;
      end
   end

   // Output register: it only changes when empty or consumed, so a stalled result stays put.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v3     <= 1'b0;
         result <= '0;
         flags  <= '0;
      end else if (rdy3) begin
         v3     <= v2;
         result <= res_d;
         flags  <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp_mul_pipe.sv
// tb_fp_mul_pipe: directed checks of the half-precision multiplier.
// Also checks one single-precision instance.
module tb_fp_mul_pipe;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // half-precision DUT
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] a, b, result;
  logic [3:0]  flags;

  // single-precision DUT
  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] a32, b32, result32;
  logic [3:0]  flags32;

  int passed = 0;
  int total  = 0;

  fp_mul_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags)
  );

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid32), .in_ready(in_ready32), .a(a32), .b(b32),
    .out_valid(out_valid32), .out_ready(out_ready32), .result(result32), .flags(flags32)
  );

  // ---------------- driver ----------------
  // Offer one pair and wait for its result with out_ready high.
  // lat counts rising edges, with the accepting edge counted as 1.
  // lat is -2 if the pair is never accepted and -1 if no result appears.
  task automatic do_op(input logic [15:0] oa, input logic [15:0] ob,
                       output logic [15:0] res, output logic [3:0] fl, output int lat);
    int n;
    logic accepted;
    res = '0; fl = '0; lat = -2; accepted = 1'b0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = oa; b = ob;
    for (int i = 0; i < 10 && !accepted; i++) begin
      #1;
      accepted = in_ready;
      @(posedge clk);
      if (!accepted) @(negedge clk);
    end
    if (accepted) begin
      lat = -1;
      n = 1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) begin
          res = result; fl = flags; lat = n;
          break;
        end
        @(posedge clk); n++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  // Run a table of directed vectors and check result, flags and latency.
  task automatic run_table(input string name, input int cnt,
                           input logic [15:0] ta [8], input logic [15:0] tb_ [8],
                           input logic [15:0] te [8], input logic [3:0] tf [8]);
    logic [15:0] res;
    logic [3:0]  fl;
    int lat;
    for (int i = 0; i < cnt; i++) begin
      do_op(ta[i], tb_[i], res, fl, lat);
      total++;
      if (res !== te[i]) $display("FAIL %s[%0d] result: got %h want %h", name, i, res, te[i]);
      else passed++;
      total++;
      if (fl !== tf[i]) $display("FAIL %s[%0d] flags: got %b want %b", name, i, fl, tf[i]);
      else passed++;
      total++;
      if (lat !== 3) $display("FAIL %s[%0d] latency: got %0d want 3", name, i, lat);
      else passed++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    in_valid32 = 1'b0; out_ready32 = 1'b1; a32 = '0; b32 = '0;
    #3;
    total++;
    if (out_valid !== 1'b0) $display("FAIL reset out_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (result !== 16'h0000 || flags !== 4'b0000)
      $display("FAIL reset outputs: got %h/%b want 0000/0000", result, flags);
    else passed++;
    total++;
    if (out_valid32 !== 1'b0) $display("FAIL reset out_valid32: got %b want 0", out_valid32);
    else passed++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) $display("FAIL reset in_ready: got %b want 1", in_ready);
    else passed++;
  endtask

  task automatic test_basic();
    logic [15:0] ta [8] = '{16'h3C00, 16'hC000, 16'h0001, 16'h8000, 0, 0, 0, 0};
    logic [15:0] tb_ [8] = '{16'h4000, 16'h4200, 16'h3C00, 16'h3C00, 0, 0, 0, 0};
    logic [15:0] te [8] = '{16'h4000, 16'hC600, 16'h0000, 16'h8000, 0, 0, 0, 0};
    logic [3:0]  tf [8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 0, 0, 0, 0};
    run_table("basic", 4, ta, tb_, te, tf);
  endtask

  task automatic test_rounding();
    logic [15:0] ta [8] = '{16'h3E00, 16'h3C01, 16'h3E00, 16'h3E00, 0, 0, 0, 0};
    logic [15:0] tb_ [8] = '{16'h3E00, 16'h3C01, 16'h3C01, 16'h3C03, 0, 0, 0, 0};
    logic [15:0] te [8] = '{16'h4080, 16'h3C02, 16'h3E02, 16'h3E04, 0, 0, 0, 0};
    logic [3:0]  tf [8] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 0, 0, 0, 0};
    run_table("round", 4, ta, tb_, te, tf);
  endtask

  task automatic test_extremes();
    logic [15:0] ta [8] = '{16'h7BFF, 16'h0400, 16'hFBFF, 0, 0, 0, 0, 0};
    logic [15:0] tb_ [8] = '{16'h7BFF, 16'h3800, 16'h7BFF, 0, 0, 0, 0, 0};
    logic [15:0] te [8] = '{16'h7C00, 16'h0000, 16'hFC00, 0, 0, 0, 0, 0};
    logic [3:0]  tf [8] = '{4'b0101, 4'b0011, 4'b0101, 0, 0, 0, 0, 0};
    run_table("extreme", 3, ta, tb_, te, tf);
  endtask

  task automatic test_specials();
    logic [15:0] ta [8] = '{16'h7C00, 16'h7D00, 16'hFC00, 16'hFE00, 16'hFC00, 0, 0, 0};
    logic [15:0] tb_ [8] = '{16'h0000, 16'h3C00, 16'h4000, 16'h3C00, 16'h8000, 0, 0, 0};
    logic [15:0] te [8] = '{16'h7E00, 16'h7E00, 16'hFC00, 16'h7E00, 16'h7E00, 0, 0, 0};
    logic [3:0]  tf [8] = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 0, 0, 0};
    run_table("special", 5, ta, tb_, te, tf);
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [5] = '{16'h3C00, 16'h4000, 16'h4200, 16'hC000, 16'h3800};
    logic [15:0] vb [5] = '{16'h4000, 16'h4000, 16'h4000, 16'h4200, 16'h3800};
    logic [15:0] ve [5] = '{16'h4000, 16'h4400, 16'h4600, 16'hC600, 16'h3400};
    logic [15:0] exp_q[$];
    logic [15:0] want;
    int idx, got, first_block, idx_at_release, last_fire;
    logic acc, fire;
    idx = 0; got = 0; first_block = -1; idx_at_release = -1; last_fire = -1;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (idx < 5);
      if (idx < 5) begin a = va[idx]; b = vb[idx]; end
      #1;
      if (cyc == 6) idx_at_release = idx;
      if (in_valid && !in_ready && first_block < 0) first_block = idx;
      acc  = in_valid && in_ready;
      fire = out_valid && out_ready;
      if (out_valid && !out_ready && exp_q.size() > 0) begin
        total++;
        if (result !== exp_q[0]) $display("FAIL b2b stall hold: got %h want %h", result, exp_q[0]);
        else passed++;
      end
      if (acc) exp_q.push_back(ve[idx]);
      if (fire) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        total++;
        if (result !== want || flags !== 4'b0000)
          $display("FAIL b2b result %0d: got %h/%b want %h/0000", got, result, flags, want);
        else passed++;
        got++;
        last_fire = cyc;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    total++;
    if (first_block !== 3) $display("FAIL b2b in_ready drop: got after %0d accepts want 3", first_block);
    else passed++;
    total++;
    if (idx_at_release !== 3) $display("FAIL b2b accepts while stalled: got %0d want 3", idx_at_release);
    else passed++;
    total++;
    if (got !== 5) $display("FAIL b2b results out: got %0d want 5", got);
    else passed++;
    total++;
    if (last_fire !== 10) $display("FAIL b2b last result cycle: got %0d want 10", last_fire);
    else passed++;
  endtask

  task automatic test_reset_in_flight();
    logic [15:0] res;
    logic [3:0]  fl;
    int lat, stale;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 16'h4000; b = 16'h4200;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1) $display("FAIL flight pre-reset out_valid: got %b want 1", out_valid);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0) $display("FAIL flight async clear out_valid: got %b want 0", out_valid);
    else passed++;
    total++;
    if (result !== 16'h0000 || flags !== 4'b0000)
      $display("FAIL flight async clear outputs: got %h/%b want 0000/0000", result, flags);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    total++;
    if (stale !== 0) $display("FAIL flight stale results: got %0d want 0", stale);
    else passed++;
    do_op(16'h4000, 16'h4000, res, fl, lat);
    total++;
    if (res !== 16'h4400 || fl !== 4'b0000 || lat !== 3)
      $display("FAIL flight next op: got %h/%b lat %0d want 4400/0000 lat 3", res, fl, lat);
    else passed++;
  endtask

  task automatic test_fp32();
    logic [31:0] ta [2] = '{32'h3F800000, 32'hC0000000};
    logic [31:0] tb_ [2] = '{32'h40000000, 32'h40400000};
    logic [31:0] te [2] = '{32'h40000000, 32'hC0C00000};
    int n;
    logic seen;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid32 = 1'b1; a32 = ta[i]; b32 = tb_[i];
      #1;
      total++;
      if (in_ready32 !== 1'b1) $display("FAIL fp32[%0d] in_ready: got %b want 1", i, in_ready32);
      else passed++;
      @(posedge clk);
      @(negedge clk);
      in_valid32 = 1'b0;
      n = 1; seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        if (out_valid32) seen = 1'b1;
        else begin
          @(posedge clk); n++;
          @(negedge clk);
        end
      end
      total++;
      if (!seen || n !== 3) $display("FAIL fp32[%0d] latency: got %0d want 3", i, seen ? n : -1);
      else passed++;
      total++;
      if (result32 !== te[i] || flags32 !== 4'b0000)
        $display("FAIL fp32[%0d] result: got %h/%b want %h/0000", i, result32, flags32, te[i]);
      else passed++;
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_extremes();
    test_specials();
    test_back_to_back();
    test_reset_in_flight();
    test_fp32();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp_mul_pipe.md
FP_MUL_PIPE -- requirements
Module: fp_mul_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 5, exponent field width (half precision).
REQ-002 SHALL have parameter MAN_W, default 10, stored fraction width; word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  1  operand pair offered.
REQ-006 SHALL have port in_ready  output  1  operand pair accepted when in_valid&&in_ready.
REQ-007 SHALL have ports a, b  input  W  IEEE-754-style operands {sign, exp, frac}.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  result consumed when out_valid&&out_ready.
REQ-010 SHALL have port result  output  W  packed product.
REQ-011 SHALL have port flags  output  4  {invalid, overflow, underflow, inexact}, aligned with result.

Function
REQ-012 SHALL use bias = 2^(EXP_W-1)-1; normal operands carry hidden 1 (significand MAN_W+1 bits).
REQ-013 SHALL treat exp==0 operands (zero, subnormal) as signed zero (flush-to-zero on input).
REQ-014 SHALL compute sign = sign_a XOR sign_b for all results, canonical NaN excepted.
REQ-015 SHALL be a 3-stage pipeline: S1 unpack/special-case detect/exponent sum (EXP_W+2-bit signed); S2 (2*MAN_W+2)-bit significand product; S3 normalise/round/pack.
REQ-016 SHALL deliver a result on out_valid exactly 3 cycles after acceptance when out_ready is held high; throughput 1 per cycle.
REQ-017 SHALL advance each stage register when it is empty or its successor advances; in_ready = S1 empty or S1 advancing; no combinational path from in_valid to out_valid.
REQ-018 SHALL hold result/flags stable while out_valid&&!out_ready; no loss, duplication or reordering under any stall pattern.
REQ-019 SHALL normalise: product >= 2.0 -> shift right 1, exponent +1.
REQ-020 SHALL round to nearest, ties to even, using guard and sticky (OR of all lower bits); rounding carry-out renormalises and increments exponent.
REQ-021 SHALL set inexact when any discarded bit is 1 or on overflow/underflow.
REQ-022 SHALL on biased exponent >= 2^EXP_W-1 after rounding output signed infinity, overflow=1, inexact=1.
REQ-023 SHALL on biased exponent <= 0 output signed zero, underflow=1, inexact=1.
REQ-024 SHALL output canonical quiet NaN {0, all-ones exp, 1 followed by zeros} if either operand is NaN, invalid=1 only for signalling NaN input (frac MSB 0).
REQ-025 SHALL output canonical NaN with invalid=1 for infinity x zero.
REQ-026 SHALL output signed infinity, flags 0, for infinity x nonzero finite; signed zero, flags 0, for zero x finite.

Reset
REQ-027 SHALL on rst_n low clear all stage valids, out_valid=0, result=0, flags=0 immediately, independent of clk.
REQ-028 SHALL drive in_ready=1 from first cycle after reset release.
REQ-029 SHALL discard all in-flight operations on reset mid-operation; none emerge afterwards.

Verification
REQ-030 SHALL cover (defaults) 0x3C00 x 0x4000 -> 0x4000, flags 0, out_valid 3 cycles after accept; 0xC000 x 0x4200 -> 0xC600.
REQ-031 SHALL cover rounding: 0x3E00 x 0x3E00 -> 0x4080, inexact 0; 0x3C01 x 0x3C01 -> 0x3C02, inexact 1.
REQ-032 SHALL cover extremes: 0x7BFF x 0x7BFF -> 0x7C00, flags 0b0101; 0x0400 x 0x3800 -> 0x0000, flags 0b0011.
REQ-033 SHALL cover specials: 0x7C00 x 0x0000 -> 0x7E00, flags 0b1000; 0x7D00 x 0x3C00 -> 0x7E00, invalid 1; 0xFC00 x 0x4000 -> 0xFC00, flags 0.
REQ-034 SHALL cover backpressure: 5 back-to-back pairs, out_ready low 6 cycles -> in_ready drops after 3 accepts, all 5 results emerge in order once out_ready high.
REQ-035 SHALL cover rst_n pulsed low with 3 ops in flight -> out_valid 0 at once, no stale result after release, next op correct; repeat REQ-030 with EXP_W=8, MAN_W=23 (0x3F800000 x 0x40000000 -> 0x40000000).
